// File: rtl/booth_r4_serial_encoder_if.sv
// Operand-in / Booth-digit-out bus for booth_r4_serial_encoder.
// The slave modport is the encoder side. The master modport is the operand producer and digit consumer.
interface booth_r4_serial_encoder_if #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
);
  localparam int NDIG = SIGNED ? WIDTH / 2 : WIDTH / 2 + 1;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Both channels: a transfer happens on a rising edge where valid && ready.
  // Once valid is raised it holds, with its payload stable, until that transfer.
  // Ready may change freely and never feeds back combinationally into valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             dig_valid;
  logic             dig_ready;
  logic [2:0]       dig_code;
  logic [IDXW-1:0]  dig_idx;
  logic             dig_last;
  logic             busy;
  logic             dbg_state;

  modport master (
    output in_valid, in_x, dig_ready,
    input  in_ready, dig_valid, dig_code, dig_idx, dig_last, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_x, dig_ready,
    output in_ready, dig_valid, dig_code, dig_idx, dig_last, busy, dbg_state
  );
endinterface

// File: rtl/booth_r4_serial_encoder.sv
// Serial radix-4 Booth recoder: takes one operand and emits digits LSB first, code = {one, two, neg}.
// Optional BOOTH_SKIP_ZERO_EN: only nonzero-magnitude digits are emitted.
module booth_r4_serial_encoder #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic rst_n,
  booth_r4_serial_encoder_if.slave bus
);
  localparam int NDIG = SIGNED ? WIDTH / 2 : WIDTH / 2 + 1;
  localparam int XW   = 2 * NDIG;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XW:0]     opnd_q, opnd_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            ready_q;
  logic            load;
  logic [XW-1:0]   xe;
  logic [XW:0]     load_val;
  logic [2:0]      trip;
  logic [2:0]      code;
  logic            last;
  logic [IDXW-1:0] first_idx;
  logic [IDXW-1:0] next_idx;

  function automatic logic [2:0] booth_code(input logic [2:0] t);
    return {t[1] ^ t[0], (t[1] == t[0]) && (t[1] != t[2]), t[2]};
  endfunction

  assign xe       = XW'(bus.in_x);
  assign load_val = {xe, 1'b0};
  assign load     = (state_q == S_IDLE) && bus.in_valid && ready_q;
  assign trip     = 3'(opnd_q >> {idx_q, 1'b0});

`ifdef BOOTH_SKIP_ZERO_EN
  logic [NDIG-1:0] mask_q, mask_d, load_mask;

  function automatic logic [NDIG-1:0] nz_mask(input logic [XW:0] v);
    logic [2:0] t;
    nz_mask = '0;
    for (int k = 0; k < NDIG; k++) begin
      t = 3'(v >> (2 * k));
      nz_mask[k] = (t != 3'b000) && (t != 3'b111);
    end
  endfunction

  // Lowest set mask bit at or above 'from'; falls back to the top digit when none is set.
  function automatic logic [IDXW-1:0] first_set(input logic [NDIG-1:0] m, input int from);
    first_set = IDXW'(NDIG - 1);
    for (int k = NDIG - 1; k >= 0; k--) begin
      if (k >= from && m[k]) first_set = IDXW'(k);
    end
  endfunction

  always_comb begin
    load_mask = nz_mask(load_val);
    mask_d    = load ? load_mask : mask_q;
    first_idx = first_set(load_mask, 0);
    next_idx  = first_set(mask_q, int'(idx_q) + 1);
    last      = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (k > int'(idx_q) && mask_q[k]) last = 1'b0;
    end
    // An all-zero operand still yields one digit, forced to plain zero.
    code = (mask_q == '0) ? 3'b000 : booth_code(trip);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end
`else
  always_comb begin
    first_idx = '0;
    next_idx  = idx_q + 1'b1;
    last      = (idx_q == IDXW'(NDIG - 1));
    code      = booth_code(trip);
  end
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          opnd_d  = load_val;
          idx_d   = first_idx;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.dig_ready) begin
          if (last) state_d = S_IDLE;
          else      idx_d   = next_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.dig_valid = (state_q == S_EMIT);
  assign bus.busy      = (state_q == S_EMIT);
  assign bus.dbg_state = state_q;
  assign bus.dig_code  = (state_q == S_EMIT) ? code : 3'b000;
  assign bus.dig_idx   = (state_q == S_EMIT) ? idx_q : '0;
  assign bus.dig_last  = (state_q == S_EMIT) && last;
endmodule

// File: tb/tb_booth_r4_serial_encoder.sv
// Bench for booth_r4_serial_encoder: directed cases on an 8-bit signed instance,
// then random operands on six WIDTH/SIGNED configurations against an arithmetic digit model.
module tb_booth_r4_serial_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rand_go  = 1'b0;
  int   rand_done = 0;

  localparam int NOPS = 40;
`ifdef BOOTH_SKIP_ZERO_EN
  localparam int N0A = 3;
`else
  localparam int N0A = 4;
`endif
  logic [2:0] tbl_0a [4] = '{3'b011, 3'b101, 3'b100, 3'b000};

  always #5 clk = ~clk;

  booth_r4_serial_encoder_if #(.WIDTH(8), .SIGNED(1'b1)) bus ();
  booth_r4_serial_encoder #(.WIDTH(8), .SIGNED(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference digit value d_k = x[2k-1] + x[2k] - 2*x[2k+1], with x[-1] = 0.
  function automatic int xb(input logic [31:0] x, input int i);
    return (i < 0) ? 0 : int'(x[i]);
  endfunction

  function automatic int digit_val(input logic [31:0] x, input int k);
    return xb(x, 2 * k - 1) + xb(x, 2 * k) - 2 * xb(x, 2 * k + 1);
  endfunction

  function automatic logic [2:0] code_of(input logic [31:0] x, input int k);
    int d;
    d = digit_val(x, k);
    return {(d == 1 || d == -1), (d == 2 || d == -2), xb(x, 2 * k + 1) == 1};
  endfunction

  // ---------------- directed driver tasks ----------------
  task automatic send_op(input logic [7:0] x);
    int g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    while (!bus.in_ready && g < 20) begin @(negedge clk); g++; end
    check("send_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic take_digit(input string tag, input logic [2:0] c, input int k, input logic l);
    int g = 0;
    @(negedge clk);
    while (!bus.dig_valid && g < 20) begin @(negedge clk); g++; end
    check({tag, "_valid"}, bus.dig_valid, 1);
    check({tag, "_code"}, bus.dig_code, c);
    check({tag, "_idx"}, bus.dig_idx, k);
    check({tag, "_last"}, bus.dig_last, l);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_inrdy"}, bus.in_ready, 0);
    bus.dig_ready = 1'b1;
    @(posedge clk);
    #1 bus.dig_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_inrdy"}, bus.in_ready, 0);
    check({tag, "_valid"}, bus.dig_valid, 0);
    check({tag, "_code"}, bus.dig_code, 0);
    check({tag, "_idx"}, bus.dig_idx, 0);
    check({tag, "_last"}, bus.dig_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // ---------------- random configurations ----------------
  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int W  = (g < 2) ? 4 : (g < 4) ? 8 : 16;
    localparam bit S  = (g % 2) == 0;
    localparam int ND = S ? W / 2 : W / 2 + 1;

    booth_r4_serial_encoder_if #(.WIDTH(W), .SIGNED(S)) rb ();
    booth_r4_serial_encoder #(.WIDTH(W), .SIGNED(S)) u_rnd (.clk(clk), .rst_n(rst_n), .bus(rb));

    initial begin : drv
      logic [31:0] x;
      logic [31:0] msk;
      logic [11:0] exp_q[$];
      logic [11:0] e;
      int          m, sum, ref_val, guard;
      bit          seen_last, first;
      rb.in_valid  = 1'b0;
      rb.in_x      = '0;
      rb.dig_ready = 1'b0;
      msk = 32'((64'd1 << W) - 1);
      wait (rand_go);
      for (int op = 0; op < NOPS; op++) begin
        case (op)
          0:       x = msk;
          1:       x = 32'd1 << (W - 1);
          2:       x = '0;
          default: x = $urandom & msk;
        endcase
        exp_q.delete();
        for (int k = 0; k < ND; k++) begin
`ifdef BOOTH_SKIP_ZERO_EN
          if (digit_val(x, k) == 0) continue;
`endif
          exp_q.push_back({1'b0, 8'(k), code_of(x, k)});
        end
`ifdef BOOTH_SKIP_ZERO_EN
        if (exp_q.size() == 0) exp_q.push_back({1'b0, 8'(ND - 1), 3'b000});
`endif
        e = exp_q.pop_back();
        e[11] = 1'b1;
        exp_q.push_back(e);
        ref_val = (S && x[W-1]) ? int'(x) - (1 << W) : int'(x);

        @(negedge clk);
        rb.in_valid = 1'b1;
        rb.in_x     = x[W-1:0];
        guard = 0;
        while (!rb.in_ready && guard < 50) begin @(negedge clk); guard++; end
        check($sformatf("rnd%0d_accept", g), rb.in_ready, 1);
        @(posedge clk);
        #1 rb.in_valid = 1'b0;

        sum = 0; seen_last = 1'b0; first = 1'b1; guard = 0;
        while (!seen_last && guard < 400) begin
          @(negedge clk);
          guard++;
          if (first) begin
            check($sformatf("rnd%0d_latency", g), rb.dig_valid, 1);
            first = 1'b0;
          end
          rb.dig_ready = 1'($urandom_range(0, 1));
          if (rb.dig_valid && rb.dig_ready) begin
            if (exp_q.size() == 0) begin
              check($sformatf("rnd%0d_extra_digit", g), 1, 0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rnd%0d_x%0h_code", g, x), rb.dig_code, e[2:0]);
              check($sformatf("rnd%0d_x%0h_idx", g, x), rb.dig_idx, e[10:3]);
              check($sformatf("rnd%0d_x%0h_last", g, x), rb.dig_last, e[11]);
            end
            m = rb.dig_code[2] ? 1 : rb.dig_code[1] ? 2 : 0;
            if (rb.dig_code[0]) m = -m;
            sum += m * (1 << (2 * int'(rb.dig_idx)));
            seen_last = rb.dig_last;
          end
        end
        check($sformatf("rnd%0d_done", g), seen_last, 1);
        check($sformatf("rnd%0d_left", g), exp_q.size(), 0);
        check($sformatf("rnd%0d_x%0h_sum", g, x), sum, ref_val);
        @(posedge clk);
        #1 rb.dig_ready = 1'b0;
      end
      rand_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.dig_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_inrdy", bus.in_ready, 1);
    check("post_reset_valid", bus.dig_valid, 0);

    // Operand 0x0A with dig_ready high: -2, -1, +1, 0.
    send_op(8'h0A);
    @(negedge clk);
    check("t1_latency", bus.dig_valid, 1);
    for (int k = 0; k < N0A; k++) take_digit($sformatf("t1_k%0d", k), tbl_0a[k], k, k == N0A - 1);
    @(negedge clk);
    check("t1_idle_inrdy", bus.in_ready, 1);
    check("t1_idle_valid", bus.dig_valid, 0);

    // Hold digit 1 for three cycles.
    send_op(8'h0A);
    take_digit("t3_k0", 3'b011, 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t3_hold_valid", bus.dig_valid, 1);
      check("t3_hold_code", bus.dig_code, 3'b101);
      check("t3_hold_idx", bus.dig_idx, 1);
    end
    for (int k = 1; k < N0A; k++) take_digit($sformatf("t3_k%0d", k), tbl_0a[k], k, k == N0A - 1);

    // New operand held on the input while busy.
    send_op(8'h0A);
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h55;
    for (int k = 0; k < N0A; k++) take_digit($sformatf("t4_k%0d", k), tbl_0a[k], k, k == N0A - 1);
    @(negedge clk);
    check("t4_idle_inrdy", bus.in_ready, 1);
    check("t4_idle_busy", bus.busy, 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) take_digit($sformatf("t4_n_k%0d", k), 3'b100, k, k == 3);

    // Reset while digit 2 is presented.
    send_op(8'h0A);
    take_digit("t5_k0", 3'b011, 0, 1'b0);
    take_digit("t5_k1", 3'b101, 1, 1'b0);
    @(negedge clk);
    check("t5_k2_code", bus.dig_code, 3'b100);
    check("t5_k2_idx", bus.dig_idx, 2);
    #1 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    @(negedge clk);
    chk_zero("t5_low");
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rel_inrdy", bus.in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_old_digit", bus.dig_valid, 0);
    end

    rand_go = 1'b1;
    guard = 0;
    while (rand_done < 6 && guard < 40000) begin @(negedge clk); guard++; end
    check("rnd_all_done", rand_done, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
